// File: rtl/recon_pkg.sv
// Shared types and helpers for the reconstruction stage and its scan counter.
package recon_pkg;

    typedef enum logic [0:0] {
        RECON_IDLE = 1'b0,
        RECON_RUN  = 1'b1
    } recon_state_e;

    localparam int unsigned PIXEL_W    = 8;
    localparam int unsigned RESID_W    = 9;
    localparam int unsigned SUM_W      = 10;
    localparam int unsigned CLIP_CNT_W = 20;

    // Counter width that stays at least one bit for a single-valued range.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Saturate a signed 10-bit sum into the unsigned 8-bit pixel range.
    function automatic logic [7:0] clip_u8(input logic signed [9:0] sum);
        if (sum < 10'sd0) begin
            return 8'd0;
        end else if (sum > 10'sd255) begin
            return 8'hFF;
        end else begin
            return sum[7:0];
        end
    endfunction

    // Sum lies outside 0..255 exactly when either of the top two bits is set.
    function automatic logic needs_clip(input logic signed [9:0] sum);
        return sum[9] | sum[8];
    endfunction

endpackage

// File: rtl/block_scan_counter.sv
// Nested block-order scan counters: px fastest, then py, then bx, then by.
// last_o flags the final pixel of the final block of the frame.
module block_scan_counter
    import recon_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned BLOCKS_X = 80,
    parameter int unsigned BLOCKS_Y = 60,
    parameter int unsigned PW       = width_of(N),
    parameter int unsigned BXW      = width_of(BLOCKS_X),
    parameter int unsigned BYW      = width_of(BLOCKS_Y)
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           start_i,
    input  logic           advance_i,
    output logic [PW-1:0]  px_o,
    output logic [PW-1:0]  py_o,
    output logic [BXW-1:0] bx_o,
    output logic [BYW-1:0] by_o,
    output logic           last_o
);

    localparam logic [PW-1:0]  PxMax = PW'(N - 1);
    localparam logic [BXW-1:0] BxMax = BXW'(BLOCKS_X - 1);
    localparam logic [BYW-1:0] ByMax = BYW'(BLOCKS_Y - 1);

    logic [PW-1:0]  px_q, px_d;
    logic [PW-1:0]  py_q, py_d;
    logic [BXW-1:0] bx_q, bx_d;
    logic [BYW-1:0] by_q, by_d;

    logic px_wrap, py_wrap, bx_wrap, by_wrap;

    assign px_wrap = (px_q == PxMax);
    assign py_wrap = (py_q == PxMax);
    assign bx_wrap = (bx_q == BxMax);
    assign by_wrap = (by_q == ByMax);

    // Ripple-carry style advance: each level steps when all faster levels wrap.
    always_comb begin
        px_d = px_q;
        py_d = py_q;
        bx_d = bx_q;
        by_d = by_q;
        if (start_i) begin
            px_d = '0;
            py_d = '0;
            bx_d = '0;
            by_d = '0;
        end else if (advance_i) begin
            px_d = px_wrap ? '0 : px_q + 1'b1;
            if (px_wrap) begin
                py_d = py_wrap ? '0 : py_q + 1'b1;
                if (py_wrap) begin
                    bx_d = bx_wrap ? '0 : bx_q + 1'b1;
                    if (bx_wrap) begin
                        by_d = by_wrap ? '0 : by_q + 1'b1;
                    end
                end
            end
        end
    end

    // Counter state, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            px_q <= '0;
            py_q <= '0;
            bx_q <= '0;
            by_q <= '0;
        end else begin
            px_q <= px_d;
            py_q <= py_d;
            bx_q <= bx_d;
            by_q <= by_d;
        end
    end

    assign px_o   = px_q;
    assign py_o   = py_q;
    assign bx_o   = bx_q;
    assign by_o   = by_q;
    assign last_o = px_wrap & py_wrap & bx_wrap & by_wrap;

endmodule

// File: rtl/recon_stream_adder.sv
// Reconstruction stage: pred + resid, clipped to 8 bits, emitted in N x N block
// order with frame coordinates and a frame-complete pulse.
// Optional feature macro: RECON_CLIP_STATS_EN adds a per-frame clip counter.
module recon_stream_adder
    import recon_pkg::*;
#(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned N      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [7:0]                pred,
    input  logic [8:0]                resid,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_pixel,
    output logic [$clog2(WIDTH)-1:0]  out_x,
    output logic [$clog2(HEIGHT)-1:0] out_y,
`ifdef RECON_CLIP_STATS_EN
    output logic [CLIP_CNT_W-1:0]     clip_count,
`endif
    output logic                      frame_done
);

    localparam int unsigned BlocksX = WIDTH / N;
    localparam int unsigned BlocksY = HEIGHT / N;
    localparam int unsigned PW      = width_of(N);
    localparam int unsigned BXW     = width_of(BlocksX);
    localparam int unsigned BYW     = width_of(BlocksY);
    localparam int unsigned XW      = $clog2(WIDTH);
    localparam int unsigned YW      = $clog2(HEIGHT);

    recon_state_e state_q;
    logic         in_closed_q;   // last beat of the frame already taken
    logic         frame_done_q;

    logic          out_valid_q;
    logic          out_last_q;   // output register holds the frame's last pixel
    logic [7:0]    out_pixel_q;
    logic [XW-1:0] out_x_q;
    logic [YW-1:0] out_y_q;

    logic [PW-1:0]  px, py;
    logic [BXW-1:0] bx;
    logic [BYW-1:0] by;
    logic           scan_last;

    logic              start;
    logic              in_hs;
    logic              out_hs;
    logic signed [9:0] sum;
    logic [XW-1:0]     cur_x;
    logic [YW-1:0]     cur_y;

    assign start  = (state_q == RECON_IDLE) && frame_start;
    assign in_ready = (state_q == RECON_RUN) && !in_closed_q && (!out_valid_q || out_ready);
    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid_q && out_ready;

    assign sum   = $signed({2'b00, pred}) + $signed({resid[8], resid});
    assign cur_x = XW'(bx) * XW'(N) + XW'(px);
    assign cur_y = YW'(by) * YW'(N) + YW'(py);

    block_scan_counter #(
        .N        (N),
        .BLOCKS_X (BlocksX),
        .BLOCKS_Y (BlocksY),
        .PW       (PW),
        .BXW      (BXW),
        .BYW      (BYW)
    ) u_scan (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (start),
        .advance_i (in_hs),
        .px_o      (px),
        .py_o      (py),
        .bx_o      (bx),
        .by_o      (by),
        .last_o    (scan_last)
    );

    // Frame FSM: arm on frame_start, close input after the last beat, finish
    // once the last pixel leaves the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RECON_IDLE;
            in_closed_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                RECON_IDLE: begin
                    if (frame_start) begin
                        state_q     <= RECON_RUN;
                        in_closed_q <= 1'b0;
                    end
                end
                RECON_RUN: begin
                    if (in_hs && scan_last) begin
                        in_closed_q <= 1'b1;
                    end
                    if (out_hs && out_last_q) begin
                        frame_done_q <= 1'b1;
                        state_q      <= RECON_IDLE;
                    end
                end
                default: state_q <= RECON_IDLE;
            endcase
        end
    end

    // Single-entry output register; a new beat overwrites a pixel being drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pixel_q <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else if (in_hs) begin
            out_valid_q <= 1'b1;
            out_last_q  <= scan_last;
            out_pixel_q <= clip_u8(sum);
            out_x_q     <= cur_x;
            out_y_q     <= cur_y;
        end else if (out_hs) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

`ifdef RECON_CLIP_STATS_EN
    logic [CLIP_CNT_W-1:0] clip_count_q;

    // Saturating count of clipped beats in the current frame.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            clip_count_q <= '0;
        end else if (in_hs && needs_clip(sum) && (clip_count_q != '1)) begin
            clip_count_q <= clip_count_q + 1'b1;
        end
    end

    assign clip_count = clip_count_q;
`endif

    assign out_valid  = out_valid_q;
    assign out_pixel  = out_pixel_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_recon_stream_adder.sv
// Directed bench for recon_stream_adder on a 16x16 frame with 8x8 blocks.
module tb_recon_stream_adder;

    localparam int unsigned W  = 16;
    localparam int unsigned H  = 16;
    localparam int unsigned NB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] pred;
    logic [8:0] resid;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pixel;
    logic [3:0] out_x;
    logic [3:0] out_y;
    logic       frame_done;
`ifdef RECON_CLIP_STATS_EN
    logic [19:0] clip_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    recon_stream_adder #(
        .WIDTH  (W),
        .HEIGHT (H),
        .N      (NB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pred        (pred),
        .resid       (resid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pixel   (out_pixel),
        .out_x       (out_x),
        .out_y       (out_y),
`ifdef RECON_CLIP_STATS_EN
        .clip_count  (clip_count),
`endif
        .frame_done  (frame_done)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected frame coordinates of the k-th accepted beat (block raster order).
    function automatic logic [3:0] exp_x(input int k);
        return 4'(((k / 64) % 2) * 8 + (k % 8));
    endfunction

    function automatic logic [3:0] exp_y(input int k);
        return 4'((k / 128) * 8 + ((k / 8) % 8));
    endfunction

    // One clock: sample handshakes just before the edge, return 1 after it.
    task automatic step(output bit ih, output bit oh);
        #1;
        ih = in_valid && in_ready;
        oh = out_valid && out_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        pred        = '0;
        resid       = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] p, input logic [8:0] r, output bit ok);
        bit ih, oh;
        ok       = 1'b0;
        pred     = p;
        resid    = r;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            step(ih, oh);
            ok = ih;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_valid !== 1'b0 || out_pixel !== 8'd0 || out_x !== 4'd0 || out_y !== 4'd0
            || frame_done !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: v=%b pix=%0d x=%0d y=%0d done=%b rdy=%b, want all 0",
                     out_valid, out_pixel, out_x, out_y, frame_done, in_ready);
        end
    endtask

    task automatic test_clip();
        logic [7:0] pv[8] = '{8'd200, 8'd10, 8'd100, 8'd0, 8'd255, 8'd128, 8'd255, 8'd0};
        logic [8:0] rv[8] = '{9'd100, 9'h1CE, 9'h1FF, 9'h100, 9'h0FF, 9'h000, 9'h101, 9'h0FF};
        logic [7:0] ev[8] = '{8'd255, 8'd0, 8'd99, 8'd0, 8'd255, 8'd128, 8'd0, 8'd255};
        bit ok;
        apply_reset();
        start_frame();
        for (int i = 0; i < 8; i++) begin
            send_beat(pv[i], rv[i], ok);
            checks++;
            if (!ok || out_valid !== 1'b1 || out_pixel !== ev[i]
                || out_x !== 4'(i) || out_y !== 4'd0) begin
                failures++;
                $display("FAIL clip[%0d]: acc=%b v=%b pix=%0d x=%0d y=%0d, want pix=%0d x=%0d y=0",
                         i, ok, out_valid, out_pixel, out_x, out_y, ev[i], i);
            end
        end
    endtask

    task automatic test_scan();
        bit ih, oh;
        int k = 0;
        int cyc = 0;
        int dcnt = 0;
        logic [7:0] ep;
        apply_reset();
        start_frame();
        out_ready = 1'b1;
        while (k < 256 && cyc < 400) begin
            pred     = 8'(k);
            resid    = (k % 2 == 1) ? 9'h1FF : 9'h000;
            in_valid = 1'b1;
            step(ih, oh);
            cyc++;
            if (frame_done === 1'b1) dcnt++;
            if (ih) begin
                ep = (k % 2 == 1) ? 8'(k - 1) : 8'(k);
                checks++;
                if (out_pixel !== ep || out_x !== exp_x(k) || out_y !== exp_y(k)) begin
                    failures++;
                    $display("FAIL scan_beat[%0d]: pix=%0d x=%0d y=%0d, want pix=%0d x=%0d y=%0d",
                             k, out_pixel, out_x, out_y, ep, exp_x(k), exp_y(k));
                end
                if (k == 8 || k == 64 || k == 255) begin
                    checks++;
                    if (out_x !== exp_x(k) || out_y !== exp_y(k)) begin
                        failures++;
                        $display("FAIL scan_corner[%0d]: x=%0d y=%0d, want x=%0d y=%0d",
                                 k + 1, out_x, out_y, exp_x(k), exp_y(k));
                    end
                end
                k++;
            end
        end
        checks++;
        if (k != 256 || cyc != 256) begin
            failures++;
            $display("FAIL scan_throughput: beats=%0d cycles=%0d, want 256 and 256", k, cyc);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL scan_closed: in_ready=%b after last beat, want 0", in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            step(ih, oh);
            if (frame_done === 1'b1) dcnt++;
            if (ih) begin
                checks++;
                failures++;
                $display("FAIL scan_extra_beat: beat accepted after frame end, want none");
            end
        end
        in_valid = 1'b0;
        checks++;
        if (dcnt != 1) begin
            failures++;
            $display("FAIL scan_frame_done: pulses=%0d, want 1", dcnt);
        end
    endtask

    task automatic test_backpressure();
        bit ih, oh;
        int k = 0;
        int j = 0;
        int cyc = 0;
        int dcnt = 0;
        logic [7:0] pp;
        logic [3:0] px, py;
        apply_reset();
        start_frame();
        while (j < 256 && cyc < 600) begin
            in_valid  = (k < 256);
            pred      = 8'(k * 7);
            resid     = 9'h000;
            out_ready = !(cyc >= 40 && cyc < 45);
            #1;
            ih = in_valid && in_ready;
            oh = out_valid && out_ready;
            if (!out_ready) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_stall_ready[%0d]: in_ready=%b out_valid=%b, want 0 and 1",
                             cyc, in_ready, out_valid);
                end
                if (cyc > 40) begin
                    checks++;
                    if (out_pixel !== pp || out_x !== px || out_y !== py) begin
                        failures++;
                        $display("FAIL bp_stable[%0d]: pix=%0d x=%0d y=%0d, want %0d %0d %0d",
                                 cyc, out_pixel, out_x, out_y, pp, px, py);
                    end
                end
            end
            if (oh) begin
                checks++;
                if (out_pixel !== 8'(j * 7) || out_x !== exp_x(j) || out_y !== exp_y(j)) begin
                    failures++;
                    $display("FAIL bp_out[%0d]: pix=%0d x=%0d y=%0d, want pix=%0d x=%0d y=%0d",
                             j, out_pixel, out_x, out_y, 8'(j * 7), exp_x(j), exp_y(j));
                end
                j++;
            end
            pp = out_pixel;
            px = out_x;
            py = out_y;
            @(posedge clk);
            #1;
            if (ih) k++;
            if (frame_done === 1'b1) dcnt++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(ih, oh);
            if (frame_done === 1'b1) dcnt++;
        end
        checks++;
        if (j != 256 || k != 256 || dcnt != 1) begin
            failures++;
            $display("FAIL bp_totals: in=%0d out=%0d done=%0d, want 256 256 1", k, j, dcnt);
        end
    endtask

    task automatic test_back_to_back();
        bit ih, oh, ok, seen;
        int k = 0;
        int cyc = 0;
        apply_reset();
        start_frame();
        while (k < 256 && cyc < 400) begin
            pred     = 8'(k);
            resid    = 9'h000;
            in_valid = 1'b1;
            step(ih, oh);
            cyc++;
            if (ih) k++;
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(ih, oh);
            seen = (frame_done === 1'b1);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL b2b_first_done: frame_done=0 after 10 cycles, want pulse");
        end
        frame_start = 1'b1;
        pred        = 8'd42;
        step(ih, oh);
        frame_start = 1'b0;
        checks++;
        if (ih || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart: accepted_in_done_cycle=%b in_ready=%b, want 0 and 1",
                     ih, in_ready);
        end
        step(ih, oh);
        checks++;
        if (!ih || out_pixel !== 8'd42 || out_x !== 4'd0 || out_y !== 4'd0) begin
            failures++;
            $display("FAIL b2b_first_pixel: acc=%b pix=%0d x=%0d y=%0d, want 1 42 0 0",
                     ih, out_pixel, out_x, out_y);
        end
        // frame_start during RUN must not rewind the scan.
        frame_start = 1'b1;
        pred        = 8'd43;
        step(ih, oh);
        frame_start = 1'b0;
        pred        = 8'd44;
        send_beat(8'd44, 9'h000, ok);
        checks++;
        if (!ok || out_pixel !== 8'd44 || out_x !== 4'd2 || out_y !== 4'd0) begin
            failures++;
            $display("FAIL b2b_start_ignored: acc=%b pix=%0d x=%0d y=%0d, want 1 44 2 0",
                     ok, out_pixel, out_x, out_y);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ih, oh, ok;
        int k = 0;
        int cyc = 0;
        int dcnt = 0;
        apply_reset();
        start_frame();
        out_ready = 1'b0;
        while (k < 37 && cyc < 100) begin
            pred     = 8'(k + 1);
            resid    = 9'h000;
            in_valid = 1'b1;
            out_ready = 1'b1;
            step(ih, oh);
            cyc++;
            if (ih) k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_pixel !== 8'd0 || out_x !== 4'd0 || out_y !== 4'd0
            || frame_done !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: v=%b pix=%0d x=%0d y=%0d done=%b rdy=%b, want 0",
                     out_valid, out_pixel, out_x, out_y, frame_done, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(ih, oh);
            if (frame_done === 1'b1) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin
            failures++;
            $display("FAIL midreset_no_done: pulses=%0d, want 0", dcnt);
        end
        start_frame();
        send_beat(8'd77, 9'h000, ok);
        checks++;
        if (!ok || out_pixel !== 8'd77 || out_x !== 4'd0 || out_y !== 4'd0) begin
            failures++;
            $display("FAIL midreset_restart: acc=%b pix=%0d x=%0d y=%0d, want 1 77 0 0",
                     ok, out_pixel, out_x, out_y);
        end
    endtask

`ifdef RECON_CLIP_STATS_EN
    task automatic test_clip_stats();
        bit ih, oh, seen;
        int k = 0;
        int cyc = 0;
        apply_reset();
        start_frame();
        while (k < 256 && cyc < 400) begin
            if (k % 20 == 0 && k < 240) begin
                pred  = 8'd250;
                resid = 9'd100;
            end else begin
                pred  = 8'(k);
                resid = 9'h000;
            end
            in_valid = 1'b1;
            step(ih, oh);
            cyc++;
            if (ih) k++;
        end
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(ih, oh);
            seen = (frame_done === 1'b1);
        end
        step(ih, oh);
        checks++;
        if (!seen || clip_count !== 20'd12) begin
            failures++;
            $display("FAIL clip_stats_count: done_seen=%b clip_count=%0d, want 1 and 12",
                     seen, clip_count);
        end
        start_frame();
        checks++;
        if (clip_count !== 20'd0) begin
            failures++;
            $display("FAIL clip_stats_clear: clip_count=%0d, want 0", clip_count);
        end
    endtask
`endif

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        pred        = '0;
        resid       = '0;
        test_reset();
        test_clip();
        test_scan();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef RECON_CLIP_STATS_EN
        test_clip_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/recon_stream_adder.md
# recon_stream_adder

Streaming reconstruction stage directly upstream of the loop filters. It adds a signed residual to each prediction sample, clips the result to 8 bits, and emits reconstructed pixels in N×N block order with frame coordinates. It produces the frame-complete pulse that drives the loop-filter stage's `new_frame_ready`.

## Interface

One clock. Reset is synchronous and active-high.

Parameters:
- `WIDTH`, 640: frame width in pixels. Must be a multiple of `N`.
- `HEIGHT`, 480: frame height in pixels. Must be a multiple of `N`.
- `N`, 8: block size in pixels.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous active-high reset.
- `frame_start`, in, 1: one-cycle pulse that arms a new frame.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: input beat accepted when `in_valid && in_ready`.
- `pred`, in, 8: unsigned prediction sample.
- `resid`, in, 9: two's-complement residual, range −256..+255.
- `out_valid`, out, 1: output pixel valid.
- `out_ready`, in, 1: downstream accepts the output pixel.
- `out_pixel`, out, 8: reconstructed sample.
- `out_x`, out, `$clog2(WIDTH)`: frame column of `out_pixel`.
- `out_y`, out, `$clog2(HEIGHT)`: frame row of `out_pixel`.
- `frame_done`, out, 1: one-cycle pulse after the last pixel of a frame is accepted downstream.

## Operation

- Two-state FSM, IDLE and RUN. Reset state is IDLE.
- IDLE → RUN on `frame_start`. All counters are zeroed on this transition.
- `frame_start` is ignored while in RUN.
- In IDLE, `in_ready` = 0.
- In RUN, `in_ready` = `!out_valid || out_ready` (single output register, no bubble under continuous flow).
- Arithmetic:
  - sum = {1'b0, pred} + sign-extended `resid`, computed at 10 bits signed.
  - `out_pixel` = 0 if sum < 0; 255 if sum > 255; otherwise sum[7:0].
- Scan order:
  - Pixel counters `px` and `py` run raster order inside an N×N block: `px` fastest, wrapping at N−1.
  - Block counters `bx` and `by` run raster order over the frame: `bx` wraps at WIDTH/N−1.
  - `out_x` = bx·N+px and `out_y` = by·N+py, both registered alongside `out_pixel`.
  - Counters advance only on an input handshake.
- Last input beat: px = py = N−1, bx = WIDTH/N−1, by = HEIGHT/N−1.
  - After this beat, `in_ready` is forced to 0 until the FSM returns to IDLE.
  - When that pixel's output handshake completes, `frame_done` pulses the next cycle and the FSM returns to IDLE.
- `frame_start` on the same cycle as the `frame_done` pulse is honoured: the FSM returns to RUN immediately.
- Output stall: `out_pixel`, `out_x` and `out_y` hold stable while `out_valid && !out_ready`.
- Reset mid-frame discards the output register contents and any partial frame. No `frame_done` is issued for the aborted frame.

## Timing

- Latency: input handshake in cycle t gives `out_valid` in cycle t+1.
- Throughput: one pixel per cycle when `out_ready` is held high.
- Reset values:
  - `out_valid` = 0, `out_pixel` = 0, `out_x` = 0, `out_y` = 0, `frame_done` = 0.
  - `in_ready` = 0; state = IDLE; all counters = 0.
- `frame_done` is asserted exactly one cycle per completed frame.
- Simultaneous output handshake and new input handshake in the same cycle: the output register loads the new pixel, and `out_valid` stays 1.

## Configuration

- Macro `RECON_CLIP_STATS_EN`.
- When defined:
  - Adds output `clip_count` (out, 20 bits): the number of pixels in the current frame whose sum needed clipping.
  - Counts once per input handshake with clipping.
  - Cleared on reset and on IDLE → RUN.
  - Held after `frame_done` until the next frame starts.
  - Saturates at all-ones.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Structure

- Shared package `recon_pkg`:
  - FSM state enum (`RECON_IDLE`, `RECON_RUN`).
  - Clip function `clip_u8(logic signed [9:0])`.
  - Localparams for block-grid extents (WIDTH/N, HEIGHT/N), derived in the module from the parameters.
- One sub-module, `block_scan_counter`: nested px/py/bx/by counters with advance enable, zero-on-start, and a `last` flag. It is reusable by the deblocking stage.
- The top module holds the FSM, adder/clip, and output register.

## Test plan

- Basic add and clip: pred=200, resid=+100 → out_pixel=255. pred=10, resid=−50 → 0. pred=100, resid=−1 → 99.
- Scan order with WIDTH=16, HEIGHT=16, N=8: the 9th accepted beat gives (out_x, out_y) = (0, 1); the 65th gives (8, 0); the 256th gives (15, 15), then `frame_done` pulses once.
- Backpressure: hold `out_ready`=0 for 5 cycles mid-block → `in_ready`=0 after the first beat, output fields stable, and no pixel lost or duplicated across 256 beats.
- Back-to-back frames: `frame_start` asserted in the `frame_done` cycle → the second frame starts at (0, 0) with no extra idle cycle.
- Reset mid-frame after 37 beats → all outputs 0 the next cycle, no `frame_done`, and the next frame restarts at (0, 0).
- With `RECON_CLIP_STATS_EN`: a 16×16 frame where 12 beats saturate → `clip_count`=12 after `frame_done`, cleared to 0 at the next `frame_start`.
